fir_decim_out: RTL

Output conditioning stage placed directly downstream of the 65-tap transposed-form FIR (`radix_fir_65`, 23-bit signed output, one result per clock). It discards the FIR pipeline-fill samples and decimates the stream by `DECIM`. Each kept sample is rounded and saturated to `WOUT` bits. Kept samples are buffered in a small FIFO and delivered to the polyphase combiner over a valid/ready handshake.

---
 rtl/fir_decim_out.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fir_decim_out.sv
`default_nettype none
// ============================================================================
// Module   : fir_decim_out
// Purpose  : Output conditioning for the 65-tap transposed FIR. Discards the
//            pipeline-fill samples, decimates by DECIM, rounds and saturates
//            each kept sample to WOUT bits, and buffers it in a small
//            show-ahead FIFO with a valid/ready output.
// Ports    : clk, reset (async, active-low)
//            din[WIN-1:0], din_en      - FIR sample stream
//            m_data, m_valid, m_ready  - output handshake
//            overflow                  - sticky, kept sample dropped (FIFO full)
//            sat                       - pulse, sample just written was clipped
//            level                     - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fir_decim_out #(
  parameter int WIN    = 23,
  parameter int WOUT   = 16,
  parameter int SHIFT  = 7,
  parameter int DECIM  = 4,
  parameter int WARMUP = 65,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIN-1:0]           din,
  input  logic                     din_en,
  output logic [WOUT-1:0]          m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overflow,
  output logic                     sat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = 10;  // holds WARMUP up to 1023
  localparam int PHW = 8;   // holds phase up to 255

  localparam logic [WCW-1:0]        WARM_END = WCW'(WARMUP);
  localparam logic [PHW-1:0]        PH_LAST  = PHW'(DECIM - 1);
  localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
  localparam logic signed [WIN:0]   HALF     = (WIN+1)'(2 ** (SHIFT - 1));
  localparam logic signed [WIN:0]   MAXV     = (WIN+1)'((2 ** (WOUT - 1)) - 1);
  localparam logic signed [WIN:0]   MINV     = (WIN+1)'(-(2 ** (WOUT - 1)));

  // --------------------------------------------------------------------------
  // Warm-up and decimation phase counters
  // --------------------------------------------------------------------------
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic           keep;

  always_comb begin
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (din_en) begin
      if (wcnt_q != WARM_END) begin
        wcnt_d = wcnt_q + WCW'(1);
      end else begin
        keep    = (phase_q == '0);
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);
      end
    end
  end

  // Input capture register: holds the kept raw sample for the rounding stage.
  logic           in_valid_q;
  logic [WIN-1:0] in_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q     <= '0;
      phase_q    <= '0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      phase_q    <= phase_d;
      in_valid_q <= keep;
      if (keep) in_data_q <= din;
    end
  end

  // --------------------------------------------------------------------------
  // Round half toward +inf, then clip to the signed WOUT range
  // --------------------------------------------------------------------------
  logic signed [WIN:0]  sum_w;
  logic signed [WIN:0]  t_w;
  logic [WOUT-1:0]      rnd_d;
  logic                 clip_d;

  always_comb begin
    sum_w  = $signed({in_data_q[WIN-1], in_data_q}) + HALF;
    t_w    = sum_w >>> SHIFT;
    clip_d = 1'b0;
    rnd_d  = t_w[WOUT-1:0];
    if (t_w > MAXV) begin
      rnd_d  = MAXV[WOUT-1:0];
      clip_d = 1'b1;
    end else if (t_w < MINV) begin
      rnd_d  = MINV[WOUT-1:0];
      clip_d = 1'b1;
    end
  end

  logic            s1_valid_q;
  logic [WOUT-1:0] s1_data_q;
  logic            s1_sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_q;
      s1_data_q  <= rnd_d;
      s1_sat_q   <= clip_d;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [WOUT-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, sat_q;
  logic            full, pop, wr, drop;

  always_comb begin
    full = (level_q == LVL_FULL);
    pop  = m_valid & m_ready;
    // A full FIFO still accepts the write when a word leaves the same cycle.
    wr   = s1_valid_q & (~full | pop);
    drop = s1_valid_q & full & ~pop;
    level_d = level_q;
    if (wr & ~pop)      level_d = level_q + LW'(1);
    else if (~wr & pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= overflow_q | drop;
      sat_q      <= wr & s1_sat_q;
    end
  end

  // Storage carries no reset; the output mux masks stale contents.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= s1_data_q;
  end

  assign m_valid  = (level_q != '0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign sat      = sat_q;

endmodule
`default_nettype wire
